// File: rtl/cla_pipe_addsub.sv
// Pipelined add/subtract: one 4-bit carry-lookahead group is resolved per stage,
// with a valid/ready handshake that freezes the whole pipe when the output is blocked.
module cla_pipe_addsub #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             ovf
);
    localparam int GROUPS = WIDTH / 4;
    localparam int LAST   = GROUPS - 1;

    if ((WIDTH % 4) != 0 || WIDTH < 4) begin : g_width_check
        $error("cla_pipe_addsub: WIDTH must be a positive multiple of 4");
    end

    // Returns {carry into bit 3, carry out of bit 3, sum[3:0]}.
    function automatic logic [5:0] cla4(input logic [3:0] x, input logic [3:0] y,
                                        input logic ci);
        logic [3:0] p;
        logic [3:0] g;
        logic [3:0] c;
        p    = x ^ y;
        g    = x & y;
        c[0] = g[0] | (p[0] & ci);
        c[1] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
        c[2] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
        c[3] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
             | (p[3] & p[2] & p[1] & p[0] & ci);
        return {c[2], c[3], p ^ {c[2:0], ci}};
    endfunction

    // Operand registers shift right by one group per stage, so the group a stage
    // works on always sits in bits [3:0] of the previous stage's register.
    logic [WIDTH-1:0]  a_p [GROUPS];
    logic [WIDTH-1:0]  b_p [GROUPS];
    logic [WIDTH-1:0]  s_p [GROUPS];
    logic [GROUPS-1:0] c_p;
    logic [GROUPS-1:0] vld_p;
    logic              ovf_p;
    logic [5:0]        grp [GROUPS];
    logic [WIDTH-1:0]  b_in;
    logic              stall;

    assign stall    = vld_p[LAST] & ~out_ready;
    assign in_ready = ~stall;
    assign b_in     = b ^ {WIDTH{sub}};

    always_comb begin
        grp[0] = cla4(a[3:0], b_in[3:0], sub);
        for (int k = 1; k < GROUPS; k++) begin
            grp[k] = cla4(a_p[k-1][3:0], b_p[k-1][3:0], c_p[k-1]);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_p <= '0;
            c_p   <= '0;
            ovf_p <= 1'b0;
            for (int k = 0; k < GROUPS; k++) begin
                a_p[k] <= '0;
                b_p[k] <= '0;
                s_p[k] <= '0;
            end
        end else if (!stall) begin
            // stage 0: group 0 from the raw inputs
            vld_p[0] <= in_valid;
            a_p[0]   <= a >> 4;
            b_p[0]   <= b_in >> 4;
            s_p[0]   <= WIDTH'(grp[0][3:0]);
            c_p[0]   <= grp[0][4];
            // stage k: group k, carry-in from stage k-1
            for (int k = 1; k < GROUPS; k++) begin
                vld_p[k]         <= vld_p[k-1];
                a_p[k]           <= a_p[k-1] >> 4;
                b_p[k]           <= b_p[k-1] >> 4;
                s_p[k]           <= s_p[k-1];
                s_p[k][4*k +: 4] <= grp[k][3:0];
                c_p[k]           <= grp[k][4];
            end
            ovf_p <= grp[LAST][5] ^ grp[LAST][4];
        end
    end

    // The last stage has no group left to hand on, so its operand copies are dead.
    logic unused_ops;
    assign unused_ops = ^{a_p[LAST], b_p[LAST]};

    assign out_valid = vld_p[LAST];
    assign s         = s_p[LAST];
    assign cout      = c_p[LAST];
    assign ovf       = ovf_p;
endmodule

// File: tb/tb_cla_pipe_addsub.sv
// Scoreboard bench: 4-, 16- and 32-bit cla_pipe_addsub instances driven in lockstep
// and checked against a plain-integer add/subtract reference.
module tb_cla_pipe_addsub;
    localparam int NI = 3;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [NI-1:0] in_valid, in_ready, sub, out_valid, out_ready, cout, ovf;
    logic [31:0]   a [NI];
    logic [31:0]   b [NI];
    logic [31:0]   s [NI];
    logic [3:0]    s0;
    logic [15:0]   s1;
    logic [31:0]   s2;

    int          cyc = 0;
    int          total = 0;
    int          passed = 0;
    bit          exact_lat;
    logic [33:0] exp_q [NI][$];
    int          cyc_q [NI][$];
    bit          held_v [NI];
    logic [33:0] held [NI];

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    cla_pipe_addsub #(.WIDTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .a(a[0][3:0]), .b(b[0][3:0]), .sub(sub[0]), .out_valid(out_valid[0]),
        .out_ready(out_ready[0]), .s(s0), .cout(cout[0]), .ovf(ovf[0]));

    cla_pipe_addsub #(.WIDTH(16)) dut16 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .a(a[1][15:0]), .b(b[1][15:0]), .sub(sub[1]), .out_valid(out_valid[1]),
        .out_ready(out_ready[1]), .s(s1), .cout(cout[1]), .ovf(ovf[1]));

    cla_pipe_addsub #(.WIDTH(32)) dut32 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
        .a(a[2]), .b(b[2]), .sub(sub[2]), .out_valid(out_valid[2]),
        .out_ready(out_ready[2]), .s(s2), .cout(cout[2]), .ovf(ovf[2]));

    always_comb begin
        s[0] = {28'd0, s0};
        s[1] = {16'd0, s1};
        s[2] = s2;
    end

    function automatic int wid(int i);
        return (i == 0) ? 4 : (i == 1) ? 16 : 32;
    endfunction

    function automatic logic [31:0] msk(int i, logic [31:0] x);
        logic [31:0] m;
        m = (wid(i) == 32) ? 32'hFFFF_FFFF : ((32'd1 << wid(i)) - 32'd1);
        return x & m;
    endfunction

    // Reference: integer arithmetic on unsigned and signed interpretations.
    function automatic logic [33:0] ref_op(int w, logic [31:0] x, logic [31:0] y, logic sb);
        longint m, ux, uy, r, sx, sy, sr;
        logic   co, ov;
        m  = longint'(1) << w;
        ux = longint'(x);
        uy = longint'(y);
        if (sb) begin
            r  = ux - uy;
            co = (ux >= uy);
        end else begin
            r  = ux + uy;
            co = (r >= m);
        end
        if (r < 0) r += m;
        if (r >= m) r -= m;
        sx = (ux >= m / 2) ? ux - m : ux;
        sy = (uy >= m / 2) ? uy - m : uy;
        sr = sb ? sx - sy : sx + sy;
        ov = (sr >= m / 2) || (sr < -(m / 2));
        return {ov, co, r[31:0]};
    endfunction

    task automatic check(string nm, int i, logic [39:0] act, logic [39:0] req);
        total++;
        if (act === req) passed++;
        else $display("FAIL %s w=%0d: got %h required %h", nm, wid(i), act, req);
    endtask

    // Monitor: pops the scoreboard whenever a result is consumed.
    always @(negedge clk) begin : mon
        logic [33:0] e;
        int          ec;
        for (int i = 0; i < NI; i++) begin
            if (held_v[i]) begin
                check("stall_hold", i, 40'({out_valid[i], ovf[i], cout[i], s[i]}),
                      40'({1'b1, held[i]}));
                held_v[i] = 1'b0;
            end
            if (rst_n) begin
                check("in_ready", i, 40'(in_ready[i]), 40'(!(out_valid[i] && !out_ready[i])));
                if (out_valid[i] && out_ready[i]) begin
                    if (exp_q[i].size() == 0) begin
                        check("spurious_out", i, 40'(1), 40'(0));
                    end else begin
                        e  = exp_q[i].pop_front();
                        ec = cyc_q[i].pop_front();
                        check("result", i, 40'({ovf[i], cout[i], s[i]}), 40'(e));
                        if (ec >= 0) check("latency", i, 40'(cyc), 40'(ec));
                    end
                end else if (out_valid[i]) begin
                    held[i]   = {ovf[i], cout[i], s[i]};
                    held_v[i] = 1'b1;
                end
            end
        end
    end

    task automatic cycle();
        bit acc [NI];
        @(negedge clk);
        for (int i = 0; i < NI; i++) begin
            acc[i] = rst_n && in_valid[i] && in_ready[i];
            if (acc[i]) begin
                exp_q[i].push_back(ref_op(wid(i), a[i], b[i], sub[i]));
                cyc_q[i].push_back(exact_lat ? cyc + wid(i) / 4 : -1);
            end
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < NI; i++) if (acc[i]) in_valid[i] = 1'b0;
    endtask

    task automatic issue(int i, logic [31:0] x, logic [31:0] y, logic sb);
        in_valid[i] = 1'b1;
        a[i]        = msk(i, x);
        b[i]        = msk(i, y);
        sub[i]      = sb;
    endtask

    task automatic issue_all(logic [31:0] x, logic [31:0] y, logic sb);
        for (int i = 0; i < NI; i++) issue(i, x, y, sb);
    endtask

    function automatic logic [31:0] rnd_op(int i);
        logic [31:0] msb;
        msb = 32'd1 << (wid(i) - 1);
        case ($urandom_range(0, 7))
            0:       return 32'd0;
            1:       return 32'hFFFF_FFFF;
            2:       return msb;
            3:       return msb - 32'd1;
            default: return $urandom;
        endcase
    endfunction

    task automatic idle_checks(string nm);
        @(negedge clk);
        for (int i = 0; i < NI; i++) begin
            check({nm, "_out_valid"}, i, 40'(out_valid[i]), 40'(0));
            check({nm, "_in_ready"}, i, 40'(in_ready[i]), 40'(1));
        end
        @(posedge clk);
        #1;
    endtask

    logic [31:0] dir_a [7];
    logic [31:0] dir_b [7];
    logic        dir_s [7];

    initial begin
        dir_a = '{32'hFFFF, 32'h8000, 32'h0001, 32'h0001, 32'h0002, 32'h7FFF, 32'h1234};
        dir_b = '{32'h0001, 32'h0001, 32'h0002, 32'h0001, 32'h0002, 32'h0001, 32'h1234};
        dir_s = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        rst_n     = 1'b0;
        in_valid  = '0;
        sub       = '0;
        out_ready = '1;
        exact_lat = 1'b1;
        for (int i = 0; i < NI; i++) begin
            a[i]      = '0;
            b[i]      = '0;
            held_v[i] = 1'b0;
        end
        @(posedge clk);
        #1;
        idle_checks("in_reset");
        rst_n = 1'b1;
        idle_checks("after_reset");

        // back-to-back directed operations with exact latency
        for (int n = 0; n < 7; n++) begin
            issue_all(dir_a[n], dir_b[n], dir_s[n]);
            cycle();
        end
        repeat (10) cycle();

        // fill the pipe, then block the output for three cycles
        exact_lat = 1'b0;
        for (int n = 0; n < 16; n++) begin
            for (int i = 0; i < NI; i++)
                if (!in_valid[i]) issue(i, $urandom, $urandom, 1'($urandom_range(0, 1)));
            out_ready = (n >= 6 && n < 9) ? '0 : '1;
            cycle();
        end
        out_ready = '1;
        repeat (12) cycle();

        // reset with two operations in flight
        exact_lat = 1'b1;
        issue_all($urandom, $urandom, 1'b0);
        cycle();
        issue_all($urandom, $urandom, 1'b1);
        cycle();
        rst_n = 1'b0;
        for (int i = 0; i < NI; i++) begin
            exp_q[i].delete();
            cyc_q[i].delete();
        end
        cycle();
        rst_n = 1'b1;
        repeat (5) begin
            @(negedge clk);
            for (int i = 0; i < NI; i++) check("reset_flush", i, 40'(out_valid[i]), 40'(0));
            @(posedge clk);
            #1;
        end
        issue_all(32'h0003, 32'h0005, 1'b1);
        cycle();
        repeat (10) cycle();

        // random traffic with random backpressure
        exact_lat = 1'b0;
        for (int n = 0; n < 600; n++) begin
            for (int i = 0; i < NI; i++) begin
                if (!in_valid[i] && $urandom_range(0, 3) != 0)
                    issue(i, rnd_op(i), rnd_op(i), 1'($urandom_range(0, 1)));
                out_ready[i] = ($urandom_range(0, 3) != 0);
            end
            cycle();
        end
        out_ready = '1;
        repeat (12) cycle();

        for (int i = 0; i < NI; i++) check("drained", i, 40'(exp_q[i].size()), 40'(0));
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/cla_pipe_addsub.md
CLA_PIPE_ADDSUB -- requirements
Module: cla_pipe_addsub

Interface
REQ-001 Parameter: WIDTH, default 16, operand/result width in bits; SHALL be a multiple of 4 and >= 4.
REQ-002 Derived constant: GROUPS = WIDTH/4, the number of 4-bit carry-lookahead groups and the pipeline depth.
REQ-003 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port: rst_n  input  1  synchronous, active-low reset, sampled on rising clk.
REQ-005 Port: in_valid  input  1  operand set present on a, b, sub.
REQ-006 Port: in_ready  output  1  block accepts operands this cycle.
REQ-007 Port: a  input  WIDTH  operand A.
REQ-008 Port: b  input  WIDTH  operand B.
REQ-009 Port: sub  input  1  0 = A+B, 1 = A-B.
REQ-010 Port: out_valid  output  1  result registers hold a valid result.
REQ-011 Port: out_ready  input  1  downstream consumes result this cycle.
REQ-012 Port: s  output  WIDTH  sum/difference, registered.
REQ-013 Port: cout  output  1  carry out of MSB (for subtract: 1 = no borrow).
REQ-014 Port: ovf  output  1  two's-complement signed overflow.

Function
REQ-015 Subtract SHALL be A + ~B + 1: B inverted per bit, carry-in to group 0 = 1; add uses carry-in 0.
REQ-016 Each group SHALL compute p=a^b, g=a&b per bit and a 4-bit lookahead carry chain c[i]=g[i]|(p[i]&c[i-1]), s[i]=p[i]^c[i-1].
REQ-017 Group k SHALL be evaluated in pipeline stage k (k=0..GROUPS-1), taking its carry-in from the stage k-1 carry register; unprocessed operand groups and completed sum groups SHALL be carried forward in stage registers.
REQ-018 Operands accepted on edge N (in_valid & in_ready) SHALL appear on s/cout/ovf with out_valid=1 after edge N+GROUPS-1, i.e. latency GROUPS cycles, stage 0 register being the first.
REQ-019 ovf SHALL equal carry-into-MSB XOR carry-out-of-MSB of the final group.
REQ-020 stall = out_valid & ~out_ready; in_ready SHALL equal ~stall (combinational).
REQ-021 When stall=1 every stage register including valid bits SHALL hold its value; s/cout/ovf SHALL remain stable.
REQ-022 When stall=0 all stages SHALL advance one position per cycle; a bubble (in_valid=0) SHALL propagate as a valid bit of 0.
REQ-023 Throughput SHALL be one operation per cycle with out_ready held 1; no bubbles inserted.
REQ-024 in_valid while in_ready=0 SHALL be ignored; source must hold operands until accepted.
REQ-025 Results SHALL emerge in acceptance order; none dropped or duplicated across stalls.
REQ-026 Arithmetic SHALL wrap modulo 2^WIDTH; no saturation.
REQ-027 s/cout/ovf SHALL be updated only when their stage advances; value under out_valid=0 is don't-care except after reset.

Reset
REQ-028 rst_n=0 at a rising edge SHALL clear all stage valid bits, s=0, cout=0, ovf=0, all carry registers=0.
REQ-029 Reset SHALL take priority over in_valid and stall; in-flight operations SHALL be discarded with no output produced.
REQ-030 During and in the cycle after reset, out_valid=0 and in_ready=1.

Verification (WIDTH=16, latency 4)
REQ-031 a=0xFFFF, b=0x0001, sub=0, out_ready=1 -> 4 cycles later out_valid=1, s=0x0000, cout=1, ovf=0.
REQ-032 a=0x8000, b=0x0001, sub=1 -> s=0x7FFF, cout=1, ovf=1; a=0x0001, b=0x0002, sub=1 -> s=0xFFFF, cout=0, ovf=0.
REQ-033 Four back-to-back ops (1+1, 2+2, 0x7FFF+1, 0x1234-0x1234) -> results 0x0002, 0x0004, 0x8000 (ovf=1), 0x0000 (cout=1) on four consecutive cycles.
REQ-034 Pipeline full, out_ready=0 for 3 cycles -> in_ready=0, s held unchanged; out_ready=1 -> remaining results drain in order, none lost.
REQ-035 Two ops in flight, rst_n=0 one cycle -> out_valid stays 0 for following 5 cycles; new op then completes with correct latency 4.
REQ-036 Random add/sub with random in_valid/out_ready over WIDTH=4 and WIDTH=32 -> every result matches (a±b) mod 2^WIDTH, cout and ovf match reference model.
